carry_sel_sequencer: RTL and testbench

//   Sequences the DSP slice carry-in path for single and multi-word operations.

---
 rtl/dsp_ctrl_pkg.sv | 47 ++++
 rtl/carry_seq_counter.sv | 38 +++
 rtl/carry_sel_sequencer.sv | 264 ++++++++++++++++++++++++++
 tb/tb_carry_sel_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dsp_ctrl_pkg
//   Shared definitions for the DSP slice carry-in sequencer:
//     - op-code encodings presented on OP_CODE
//     - CARRYINSEL encodings understood by the slice carry-in mux
//     - FSM state encoding (also exported on the debug state output)
//     - helper mapping an op code to the select used for its first word
// -----------------------------------------------------------------------------
package dsp_ctrl_pkg;

  // Op codes
  localparam logic [1:0] OP_SINGLE  = 2'b00;
  localparam logic [1:0] OP_WIDE    = 2'b01;
  localparam logic [1:0] OP_ROUND   = 2'b10;
  localparam logic [1:0] OP_CASCADE = 2'b11;

  // CARRYINSEL encodings
  localparam logic [2:0] SEL_CARRYIN = 3'b000;  // fabric CARRYIN
  localparam logic [2:0] SEL_PCIN_N  = 3'b001;  // ~PCIN[MSB]
  localparam logic [2:0] SEL_CASCIN  = 3'b010;  // CARRYCASCIN from neighbour slice
  localparam logic [2:0] SEL_PCIN    = 3'b011;  // PCIN[MSB]
  localparam logic [2:0] SEL_CASCOUT = 3'b100;  // own CARRYCASCOUT fed back
  localparam logic [2:0] SEL_P_N     = 3'b101;  // ~P[MSB]
  localparam logic [2:0] SEL_ROUND   = 3'b110;  // rounding constant from multiplier signs
  localparam logic [2:0] SEL_P       = 3'b111;  // P[MSB]

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Select for word 0 of an op. WIDE words after the first switch to
  // SEL_CASCOUT; that is handled in the sequencer, not here.
  function automatic logic [2:0] first_word_sel(input logic [1:0] op);
    logic [2:0] sel;
    case (op)
      OP_ROUND:   sel = SEL_ROUND;
      OP_CASCADE: sel = SEL_CASCIN;
      default:    sel = SEL_CARRYIN;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/carry_seq_counter.sv
// -----------------------------------------------------------------------------
// carry_seq_counter
//   Loadable down-counter with a terminal (zero) flag. Holds at zero rather
//   than wrapping, so a late decrement can never restart a sequence.
// Ports
//   CLK       in   1  clock, rising edge
//   RST       in   1  synchronous active-high reset (count -> 0)
//   load      in   1  load load_val (has priority over dec)
//   load_val  in   W  value to load
//   dec       in   1  decrement by one when count is non-zero
//   count     out  W  current count
//   term      out  1  count == 0
// -----------------------------------------------------------------------------
module carry_seq_counter #(
  parameter int W = 3
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         term
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign term = (count == '0);

endmodule

// File: rtl/carry_sel_sequencer.sv
// -----------------------------------------------------------------------------
// carry_sel_sequencer
//   Sequences the carry-in path of one DSP slice for single and multi-word
//   ops. An op is taken over a valid/ready handshake, the carry-in select and
//   register enables are driven word by word, the M/P pipeline is waited out,
//   and DONE pulses once when the result sits on P.
//
// Optional feature: macro CARRY_SEQ_STALL_EN adds input STALL. While STALL=1
//   in ISSUE or DRAIN all CE* are 0 and the FSM/counters freeze. Without the
//   macro there is no STALL port and sequencing never pauses.
//
// Handshake: an op transfers on a rising CLK edge where OP_VALID & OP_READY.
//   OP_READY is high only in IDLE (and low while RST is high). OP_CODE,
//   OP_WORDS and OP_CLR are sampled on that edge only; they are don't-care
//   at all other times.
//
// Ports
//   CLK            in   1      clock, rising edge
//   RST            in   1      synchronous active-high reset
//   STALL          in   1      pause ISSUE/DRAIN (CARRY_SEQ_STALL_EN only)
//   OP_VALID       in   1      op request
//   OP_READY       out  1      controller can accept an op
//   OP_CODE        in   2      00 SINGLE, 01 WIDE, 10 ROUND, 11 CASCADE
//   OP_WORDS       in   CNT_W  word count minus 1 (WIDE only)
//   OP_CLR         in   1      clear carry/round registers before issue
//   ABORT          in   1      terminate the current op
//   CARRYINSEL     out  3      carry-in mux select to the slice
//   CECARRYIN      out  1      carry-in register enable
//   CEM            out  1      M/round register enable
//   CEP            out  1      P register enable
//   RSTALLCARRYIN  out  1      carry/round register reset
//   BUSY           out  1      op in progress (CLEAR, ISSUE, DRAIN)
//   DONE           out  1      one-cycle pulse when the result is valid on P
//   dbg_state      out  3      current FSM state
//   dbg_word_cnt   out  CNT_W  words remaining after the current one
//   dbg_drain_cnt  out  2      drain cycles remaining after the current one
// -----------------------------------------------------------------------------
module carry_sel_sequencer
  import dsp_ctrl_pkg::*;
#(
  parameter int MREG     = 1,
  parameter int PREG     = 1,
  parameter int MAXWORDS = 8,
  parameter int CNT_W    = 3
) (
  input  logic             CLK,
  input  logic             RST,
`ifdef CARRY_SEQ_STALL_EN
  input  logic             STALL,
`endif
  input  logic             OP_VALID,
  output logic             OP_READY,
  input  logic [1:0]       OP_CODE,
  input  logic [CNT_W-1:0] OP_WORDS,
  input  logic             OP_CLR,
  input  logic             ABORT,
  output logic [2:0]       CARRYINSEL,
  output logic             CECARRYIN,
  output logic             CEM,
  output logic             CEP,
  output logic             RSTALLCARRYIN,
  output logic             BUSY,
  output logic             DONE,
  output state_t           dbg_state,
  output logic [CNT_W-1:0] dbg_word_cnt,
  output logic [1:0]       dbg_drain_cnt
);

  // Pipeline depth between the carry-in/M stage and P.
  localparam int               L_DRAIN    = MREG + PREG;
  localparam logic [1:0]       DRAIN_LAST = (L_DRAIN > 0) ? 2'(L_DRAIN - 1) : 2'd0;
  localparam logic [CNT_W-1:0] LAST_MAX   = CNT_W'(MAXWORDS - 1);

  state_t           state_q, state_d;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] last_q;        // index of the last word of the op
  logic [2:0]       sel_q;         // select of the most recently issued word
  logic [CNT_W-1:0] words_last_in;
  logic [CNT_W-1:0] word_cnt;
  logic             word_term;
  logic [1:0]       drain_cnt;
  logic             drain_term;
  logic             first_word;
  logic [2:0]       issue_sel;
  logic             stall;

  logic             accept;
  logic             word_dec;
  logic             drain_load;
  logic             drain_dec;
  logic             op_ready;
  logic             busy;
  logic             done;
  logic             ce_carryin;
  logic             ce_m;
  logic             ce_p;
  logic             rst_all;
  logic [2:0]       carryin_sel;

`ifdef CARRY_SEQ_STALL_EN
  assign stall = STALL;
`else
  assign stall = 1'b0;
`endif

  // Last-word index for the incoming op: only WIDE uses OP_WORDS, and an
  // out-of-range count saturates at MAXWORDS-1 instead of wrapping.
  always_comb begin
    words_last_in = '0;
    if (OP_CODE == OP_WIDE) begin
      words_last_in = (32'(OP_WORDS) >= 32'(MAXWORDS)) ? LAST_MAX : OP_WORDS;
    end
  end

  // The word counter runs down from last_q to 0, so word 0 is the cycle
  // where the count still equals the loaded value.
  assign first_word = (word_cnt == last_q);

  always_comb begin
    issue_sel = first_word_sel(op_q);
    if ((op_q == OP_WIDE) && !first_word) begin
      issue_sel = SEL_CASCOUT;
    end
  end

  carry_seq_counter #(.W(CNT_W)) u_word_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .load     (accept),
    .load_val (words_last_in),
    .dec      (word_dec),
    .count    (word_cnt),
    .term     (word_term)
  );

  carry_seq_counter #(.W(2)) u_drain_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .load     (drain_load),
    .load_val (DRAIN_LAST),
    .dec      (drain_dec),
    .count    (drain_cnt),
    .term     (drain_term)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      op_q    <= OP_SINGLE;
      last_q  <= '0;
      sel_q   <= SEL_CARRYIN;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= OP_CODE;
        last_q <= words_last_in;
      end
      if (word_dec) begin
        sel_q <= issue_sel;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    op_ready    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    ce_carryin  = 1'b0;
    ce_m        = 1'b0;
    ce_p        = 1'b0;
    rst_all     = 1'b0;
    carryin_sel = SEL_CARRYIN;
    accept      = 1'b0;
    word_dec    = 1'b0;
    drain_load  = 1'b0;
    drain_dec   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        op_ready = 1'b1;
        if (OP_VALID) begin
          accept  = 1'b1;
          state_d = OP_CLR ? ST_CLEAR : ST_ISSUE;
        end
      end

      ST_CLEAR: begin
        busy    = 1'b1;
        rst_all = 1'b1;
        state_d = ST_ISSUE;
      end

      ST_ISSUE: begin
        busy        = 1'b1;
        carryin_sel = issue_sel;
        if (!stall) begin
          ce_carryin = 1'b1;
          ce_m       = 1'b1;
          ce_p       = 1'b1;
          word_dec   = 1'b1;
          if (word_term) begin
            if (L_DRAIN == 0) begin
              state_d = ST_DONE;
            end else begin
              state_d    = ST_DRAIN;
              drain_load = 1'b1;
            end
          end
        end
      end

      ST_DRAIN: begin
        busy        = 1'b1;
        carryin_sel = sel_q;
        if (!stall) begin
          ce_p      = 1'b1;
          ce_m      = (MREG != 0);
          drain_dec = 1'b1;
          if (drain_term) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort acts in the same cycle: the slice sees RSTALLCARRYIN on the very
    // edge that returns the FSM to IDLE, and nothing further is enabled.
    // It overrides STALL as well.
    if (ABORT && busy) begin
      state_d    = ST_IDLE;
      ce_carryin = 1'b0;
      ce_m       = 1'b0;
      ce_p       = 1'b0;
      rst_all    = 1'b1;
      word_dec   = 1'b0;
      drain_load = 1'b0;
      drain_dec  = 1'b0;
    end
  end

  // The FSM sits in IDLE during reset, so ready is masked until RST drops.
  assign OP_READY      = op_ready & ~RST;
  assign BUSY          = busy;
  assign DONE          = done;
  assign CECARRYIN     = ce_carryin;
  assign CEM           = ce_m;
  assign CEP           = ce_p;
  assign RSTALLCARRYIN = rst_all;
  assign CARRYINSEL    = carryin_sel;
  assign dbg_state     = state_q;
  assign dbg_word_cnt  = word_cnt;
  assign dbg_drain_cnt = drain_cnt;

endmodule

// File: tb/tb_carry_sel_sequencer.sv
// -----------------------------------------------------------------------------
// tb_carry_sel_sequencer
//   Directed bench for carry_sel_sequencer with MREG=PREG=1, MAXWORDS=4.
//   Table of ops with hand-computed latency, word count and select sequence,
//   plus hand-written sequences for back-to-back ops, ABORT, RST mid-op and
//   (when CARRY_SEQ_STALL_EN is defined) STALL.
// -----------------------------------------------------------------------------
module tb_carry_sel_sequencer;
  import dsp_ctrl_pkg::*;

  localparam int CNT_W    = 3;
  localparam int MAXWORDS = 4;

  // ---------------------------------------------------------------- clock/reset
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic             OP_VALID;
  logic             OP_READY;
  logic [1:0]       OP_CODE;
  logic [CNT_W-1:0] OP_WORDS;
  logic             OP_CLR;
  logic             ABORT;
  logic [2:0]       CARRYINSEL;
  logic             CECARRYIN;
  logic             CEM;
  logic             CEP;
  logic             RSTALLCARRYIN;
  logic             BUSY;
  logic             DONE;
  state_t           dbg_state;
  logic [CNT_W-1:0] dbg_word_cnt;
  logic [1:0]       dbg_drain_cnt;
`ifdef CARRY_SEQ_STALL_EN
  logic             STALL;
`endif

  carry_sel_sequencer #(
    .MREG     (1),
    .PREG     (1),
    .MAXWORDS (MAXWORDS),
    .CNT_W    (CNT_W)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
`ifdef CARRY_SEQ_STALL_EN
    .STALL         (STALL),
`endif
    .OP_VALID      (OP_VALID),
    .OP_READY      (OP_READY),
    .OP_CODE       (OP_CODE),
    .OP_WORDS      (OP_WORDS),
    .OP_CLR        (OP_CLR),
    .ABORT         (ABORT),
    .CARRYINSEL    (CARRYINSEL),
    .CECARRYIN     (CECARRYIN),
    .CEM           (CEM),
    .CEP           (CEP),
    .RSTALLCARRYIN (RSTALLCARRYIN),
    .BUSY          (BUSY),
    .DONE          (DONE),
    .dbg_state     (dbg_state),
    .dbg_word_cnt  (dbg_word_cnt),
    .dbg_drain_cnt (dbg_drain_cnt)
  );

  // ---------------------------------------------------------------- scoreboard
  int checks   = 0;
  int failures = 0;
  logic [2:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic [1:0] code;
    logic [2:0] words;
    logic       clr;
    int         exp_lat;    // accept edge to DONE cycle
    int         exp_words;  // issue cycles
    logic [2:0] sel0;       // select of word 0
    logic [2:0] seln;       // select of words 1..N
  } vec_t;

  vec_t vecs[8];

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_op(input int idx);
    int done_at;
    int issued;
    int drained;
    int rst_seen;
    int bad;
    logic [2:0] last_sel;
    logic [2:0] s;
    done_at  = -1;
    issued   = 0;
    drained  = 0;
    rst_seen = 0;
    bad      = 0;
    last_sel = vecs[idx].sel0;
    exp_q.delete();
    exp_q.push_back(vecs[idx].sel0);
    for (int w = 1; w < vecs[idx].exp_words; w++) exp_q.push_back(vecs[idx].seln);

    OP_VALID = 1'b1;
    OP_CODE  = vecs[idx].code;
    OP_WORDS = vecs[idx].words;
    OP_CLR   = vecs[idx].clr;
    @(negedge CLK);
    check($sformatf("v%0d_ready", idx), OP_READY, 1);
    step();
    // Scramble the op fields after the accept; the DUT must not look again.
    OP_VALID = 1'b0;
    OP_CODE  = 2'($urandom_range(0, 3));
    OP_WORDS = 3'($urandom_range(0, 7));
    OP_CLR   = 1'($urandom_range(0, 1));

    for (int c = 1; c <= 40; c++) begin
      @(negedge CLK);
      if (DONE) begin
        done_at = c;
        if (BUSY || OP_READY || CECARRYIN || CEP || CEM) bad++;
        break;
      end
      if (OP_READY || !BUSY) bad++;
      if (RSTALLCARRYIN) begin
        rst_seen++;
        if (CECARRYIN || CEM || CEP) bad++;
      end
      if (CECARRYIN) begin
        issued++;
        if (!CEM || !CEP) bad++;
        if (exp_q.size() == 0) bad++;
        else begin
          s = exp_q.pop_front();
          last_sel = s;
          if (CARRYINSEL !== s) bad++;
        end
      end else if (CEP) begin
        drained++;
        if (!CEM || (CARRYINSEL !== last_sel)) bad++;
      end
      step();
    end

    check($sformatf("v%0d_latency", idx), done_at, vecs[idx].exp_lat);
    check($sformatf("v%0d_words", idx), issued, vecs[idx].exp_words);
    check($sformatf("v%0d_drain", idx), drained, 2);
    check($sformatf("v%0d_clear", idx), rst_seen, {31'd0, vecs[idx].clr});
    check($sformatf("v%0d_bad_cycles", idx), bad, 0);
    step();
    @(negedge CLK);
    check($sformatf("v%0d_ready_after_done", idx), {OP_READY, DONE}, 2'b10);
    step();
  endtask

  task automatic wait_idle(input string name);
    int ok;
    ok = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge CLK);
      if (OP_READY) begin
        ok = 1;
        break;
      end
      step();
    end
    check(name, ok, 1);
    if (ok == 1) step();
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------------------------------------------------------- test
  initial begin
    int acc[$];
    int first_done;
    int cnt;
    int bad;

    //            code        words clr lat nw sel0         seln
    vecs[0] = '{OP_SINGLE,  3'd5, 1'b0, 4, 1, SEL_CARRYIN, SEL_CARRYIN};
    vecs[1] = '{OP_WIDE,    3'd3, 1'b0, 7, 4, SEL_CARRYIN, SEL_CASCOUT};
    vecs[2] = '{OP_ROUND,   3'd0, 1'b1, 5, 1, SEL_ROUND,   SEL_ROUND};
    vecs[3] = '{OP_CASCADE, 3'd2, 1'b0, 4, 1, SEL_CASCIN,  SEL_CASCIN};
    vecs[4] = '{OP_WIDE,    3'd0, 1'b0, 4, 1, SEL_CARRYIN, SEL_CARRYIN};
    vecs[5] = '{OP_WIDE,    3'd7, 1'b1, 8, 4, SEL_CARRYIN, SEL_CASCOUT};
    vecs[6] = '{OP_WIDE,    3'd1, 1'b0, 5, 2, SEL_CARRYIN, SEL_CASCOUT};
    vecs[7] = '{OP_WIDE,    3'd4, 1'b0, 7, 4, SEL_CARRYIN, SEL_CASCOUT};

    OP_VALID = 1'b0;
    OP_CODE  = OP_SINGLE;
    OP_WORDS = '0;
    OP_CLR   = 1'b0;
    ABORT    = 1'b0;
`ifdef CARRY_SEQ_STALL_EN
    STALL    = 1'b0;
`endif

    // Reset values
    RST = 1'b1;
    step();
    step();
    @(negedge CLK);
    check("rst_ready", OP_READY, 0);
    check("rst_outputs", {BUSY, DONE, CECARRYIN, CEM, CEP, RSTALLCARRYIN}, 6'd0);
    check("rst_sel", CARRYINSEL, SEL_CARRYIN);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_counters", {dbg_word_cnt, dbg_drain_cnt}, 5'd0);
    step();
    RST = 1'b0;
    @(negedge CLK);
    check("ready_after_reset", OP_READY, 1);
    step();

    // Table-driven ops
    for (int i = 0; i < 8; i++) run_op(i);

    // Back-to-back: OP_VALID held high, SINGLE ops accepted at 0, 5, 10
    OP_VALID = 1'b1;
    OP_CODE  = OP_SINGLE;
    OP_WORDS = '0;
    OP_CLR   = 1'b0;
    first_done = -1;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      if (OP_READY) acc.push_back(c);
      if (DONE && (first_done < 0)) first_done = c;
      if (DONE && OP_READY) bad++;
      step();
    end
    OP_VALID = 1'b0;
    check("b2b_first_done", first_done, 4);
    check("b2b_accepts", acc.size(), 3);
    check("b2b_second_accept", (acc.size() >= 2) ? acc[1] : -1, 5);
    check("b2b_ready_in_done", bad, 0);
    wait_idle("b2b_idle");

    // ABORT during word 2 of a 4-word WIDE
    OP_VALID = 1'b1;
    OP_CODE  = OP_WIDE;
    OP_WORDS = 3'd3;
    OP_CLR   = 1'b0;
    step();                      // accepted; cycle 1 = word 0
    OP_VALID = 1'b0;
    step();                      // word 1
    @(negedge CLK);
    check("abort_word1_sel", CARRYINSEL, SEL_CASCOUT);
    step();                      // word 2
    ABORT = 1'b1;
    @(negedge CLK);
    check("abort_outputs", {CECARRYIN, CEM, CEP, RSTALLCARRYIN}, 4'b0001);
    step();
    ABORT = 1'b0;
    @(negedge CLK);
    check("abort_ready_next", {OP_READY, BUSY, RSTALLCARRYIN}, 3'b100);
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (DONE || CECARRYIN || CEP) cnt++;
      step();
    end
    check("abort_no_done", cnt, 0);

    // ABORT while IDLE is ignored
    ABORT = 1'b1;
    @(negedge CLK);
    check("abort_idle", {OP_READY, RSTALLCARRYIN, BUSY}, 3'b100);
    step();
    ABORT = 1'b0;

    // ABORT in the DONE cycle is ignored
    OP_VALID = 1'b1;
    OP_CODE  = OP_SINGLE;
    step();                      // accepted
    OP_VALID = 1'b0;
    step();                      // cycle 2
    step();                      // cycle 3
    step();                      // cycle 4 = DONE
    ABORT = 1'b1;
    @(negedge CLK);
    check("abort_in_done", {DONE, RSTALLCARRYIN}, 2'b10);
    step();
    ABORT = 1'b0;
    wait_idle("abort_done_idle");

    // RST in the middle of DRAIN
    OP_VALID = 1'b1;
    OP_CODE  = OP_SINGLE;
    step();                      // accepted; cycle 1 = ISSUE
    OP_VALID = 1'b0;
    step();                      // cycle 2 = DRAIN
    RST = 1'b1;
    @(negedge CLK);
    check("rst_mid_in_drain", {CECARRYIN, CEP}, 2'b01);
    step();
    @(negedge CLK);
    check("rst_mid_outputs",
          {OP_READY, BUSY, DONE, CECARRYIN, CEM, CEP, RSTALLCARRYIN, CARRYINSEL}, 10'd0);
    step();
    RST = 1'b0;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (DONE || !OP_READY || CEP) cnt++;
      step();
    end
    check("rst_mid_quiet", cnt, 0);

`ifdef CARRY_SEQ_STALL_EN
    // STALL for 3 cycles on WIDE word 1: DONE moves from 7 to 10
    OP_VALID = 1'b1;
    OP_CODE  = OP_WIDE;
    OP_WORDS = 3'd3;
    OP_CLR   = 1'b0;
    step();
    OP_VALID = 1'b0;
    first_done = -1;
    bad = 0;
    cnt = 0;
    for (int c = 1; c <= 30; c++) begin
      STALL = (c >= 2) && (c <= 4);
      @(negedge CLK);
      if (DONE) begin
        first_done = c;
        break;
      end
      if (STALL) begin
        cnt++;
        if (CECARRYIN || CEM || CEP) bad++;
        if (CARRYINSEL !== SEL_CASCOUT) bad++;
      end
      step();
    end
    STALL = 1'b0;
    check("stall_done", first_done, 10);
    check("stall_cycles", cnt, 3);
    check("stall_frozen", bad, 0);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
